// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with reloadable pattern
// Optional feature macro: SEQ_DET_MATCH_CNT_EN (saturating match counter; tied to 0 when undefined)
module seq_detector_param #(
  parameter int             PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int HW = PAT_W - 1;
  localparam int FW = (PAT_W <= 2) ? 1 : $clog2(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] r_pat;
  logic [HW-1:0]    r_hist;
  logic [FW-1:0]    r_fill;

  logic [PAT_W-1:0] w_pat_nxt;
  logic [HW-1:0]    w_hist_nxt;
  logic [FW-1:0]    w_fill_nxt;
  logic [HW-1:0]    w_hist_shift;
  logic             w_accept;
  logic             w_match;

  // History shift: newest bit enters at the LSB; a 2-bit pattern keeps only one bit.
  generate
    if (HW == 1) begin : g_hist_one
      assign w_hist_shift = in;
    end else begin : g_hist_many
      assign w_hist_shift = {r_hist[HW-2:0], in};
    end
  endgenerate

  assign w_accept = in_valid & ~cfg_load;
  assign w_match  = w_accept & (r_fill == FILL_MAX) & ({r_hist, in} == r_pat);
  // Reset gating keeps the strobe low for the whole reset window, not just after the flops clear.
  assign out      = reset & w_match;

  // Next-state: pattern load wins, then accepted bits shift in; bubbles hold everything.
  always_comb begin
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (cfg_load) begin
      w_pat_nxt  = cfg_pattern;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (in_valid) begin
      if (!OVERLAP && w_match) begin
        w_hist_nxt = '0;
        w_fill_nxt = '0;
      end else begin
        w_hist_nxt = w_hist_shift;
        w_fill_nxt = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FW'(1);
      end
    end
  end

  // State register; reset restores the default pattern and discards any partial history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating match counter; only reset clears it, pattern reloads leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param (three parameter variants)
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       cfg_load;
  logic [2:0] cfg_pattern;
  logic       o_ov, o_nov, o_c2;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_c2;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .out(o_ov), .match_cnt(cnt_ov));

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .out(o_nov), .match_cnt(cnt_nov));

  seq_detector_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .in(in_bit), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .out(o_c2), .match_cnt(cnt_c2));

  typedef struct {
    bit         is_cnt;
    logic [2:0] outs;
    logic [7:0] c_ov;
    logic [7:0] c_nov;
    logic [1:0] c_c2;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.is_cnt) begin
        n_chk++;
        if ({o_ov, o_nov, o_c2} === e.outs) n_pass++;
        else $display("FAIL %s out{ov,nov,c2} got %b expected %b", e.name, {o_ov, o_nov, o_c2}, e.outs);
      end else begin
        n_chk++;
        if (cnt_ov === e.c_ov) n_pass++;
        else $display("FAIL %s cnt_ov got %0d expected %0d", e.name, cnt_ov, e.c_ov);
        n_chk++;
        if (cnt_nov === e.c_nov) n_pass++;
        else $display("FAIL %s cnt_nov got %0d expected %0d", e.name, cnt_nov, e.c_nov);
        n_chk++;
        if (cnt_c2 === e.c_c2) n_pass++;
        else $display("FAIL %s cnt_c2 got %0d expected %0d", e.name, cnt_c2, e.c_c2);
      end
    end
  end

  task automatic drive(input logic v, input logic l, input logic b, input logic [2:0] pat,
                       input logic [2:0] exp_outs, input string nm);
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; cfg_load = l; in_bit = b; cfg_pattern = pat;
    e.is_cnt = 1'b0; e.outs = exp_outs; e.c_ov = '0; e.c_nov = '0; e.c_c2 = '0; e.name = nm;
    q.push_back(e);
  endtask

  task automatic seq(input logic [31:0] bits, input int n, input logic [31:0] e_ov,
                     input logic [31:0] e_nov, input string nm);
    for (int i = n - 1; i >= 0; i--)
      drive(1'b1, 1'b0, bits[i], 3'b000, {e_ov[i], e_nov[i], e_ov[i]}, $sformatf("%s_b%0d", nm, n - i));
  endtask

  task automatic bubble(input string nm);
    drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, nm);
  endtask

  task automatic cnt_check(input logic [7:0] e_ov, input logic [7:0] e_nov, input logic [1:0] e_c2,
                           input string nm);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0; in_bit = 1'b0;
    e.is_cnt = 1'b1; e.outs = 3'b000; e.name = nm;
`ifdef SEQ_DET_MATCH_CNT_EN
    e.c_ov = e_ov; e.c_nov = e_nov; e.c_c2 = e_c2;
`else
    e.c_ov = '0; e.c_nov = '0; e.c_c2 = '0;
    if (e_ov == 8'hff && e_nov == 8'hff && e_c2 == 2'd0) e.c_c2 = 2'd0;
`endif
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_bit = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cfg_pattern = 3'b000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state: counters zero, no match possible with empty history.
    cnt_check(8'd0, 8'd0, 2'd0, "reset_cnt");
    drive(1'b1, 1'b0, 1'b1, 3'b000, 3'b000, "reset_first_bit");
    do_reset();

    // 1/2: 1,0,1,0,1,1 overlapping vs non-overlapping.
    seq(32'b101011, 6, 32'b001010, 32'b001000, "t1");
    cnt_check(8'd2, 8'd1, 2'd2, "t1_cnt");
    do_reset();

    // 3: bubbles between bits never break the sequence.
    drive(1'b1, 1'b0, 1'b1, 3'b000, 3'b000, "t3_b1");
    bubble("t3_bub1"); bubble("t3_bub2");
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, "t3_b2");
    bubble("t3_bub3"); bubble("t3_bub4");
    drive(1'b1, 1'b0, 1'b1, 3'b000, 3'b111, "t3_b3");
    bubble("t3_bub5");
    cnt_check(8'd1, 8'd1, 2'd1, "t3_cnt");
    do_reset();

    // 4: load 110 in a cycle that would otherwise complete 101; load has priority.
    seq(32'b10, 2, 32'b00, 32'b00, "t4_pre");
    drive(1'b1, 1'b1, 1'b1, 3'b110, 3'b000, "t4_load");
    seq(32'b110, 3, 32'b001, 32'b001, "t4_new");
    seq(32'b1, 1, 32'b0, 32'b0, "t4_old_pat");
    cnt_check(8'd1, 8'd1, 2'd1, "t4_cnt");
    do_reset();

    // 5: reset mid-sequence discards history; strobe stays low in reset.
    seq(32'b10, 2, 32'b00, 32'b00, "t5_pre");
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1; cfg_load = 1'b0; in_bit = 1'b1;
    begin
      exp_t e;
      e.is_cnt = 1'b0; e.outs = 3'b000; e.c_ov = '0; e.c_nov = '0; e.c_c2 = '0; e.name = "t5_in_reset";
      q.push_back(e);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    seq(32'b1, 1, 32'b0, 32'b0, "t5_post");
    cnt_check(8'd0, 8'd0, 2'd0, "t5_cnt");
    do_reset();

    // 6: five overlapping matches; 2-bit counter saturates at 3 and never wraps.
    seq(32'b10101010101, 11, 32'b00101010101, 32'b00100010001, "t6a");
    cnt_check(8'd5, 8'd3, 2'd3, "t6a_cnt");
    seq(32'b10101010101, 11, 32'b00101010101, 32'b00100010001, "t6b");
    cnt_check(8'd10, 8'd6, 2'd3, "t6b_cnt");

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left %0d expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
